// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard scoreboard: default widths and
// named fixed latencies of the multi-cycle producers.
package hazard_pkg;
   localparam int REG_ADDR_W    = 5;
   localparam int NUM_ARCH_REGS = 32;
   localparam int LAT_W         = 3;

   typedef logic [LAT_W-1:0] lat_t;

   localparam lat_t LAT_ALU  = 3'd1;
   localparam lat_t LAT_LOAD = 3'd2;
   localparam lat_t LAT_MUL  = 3'd3;
endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: a countdown for fixed-latency producers and a busy
// flag for variable-latency producers. Issue overrides decrement and wb clear.
module hazard_sb_entry
   import hazard_pkg::*;
#(
   parameter int CNT_BITS = LAT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                issue_hit,
   input  logic [CNT_BITS-1:0] latency,
   input  logic                var_lat,
   input  logic                wb_hit,
   output logic                pend,
   output logic                var_busy,
   output logic                pend_nxt
);

   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                var_q, var_d;

   always_comb begin
      cnt_d = cnt_q;
      var_d = var_q;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      if (wb_hit) var_d = 1'b0;
      if (issue_hit) begin
         if (var_lat) begin
            var_d = 1'b1;
            cnt_d = '0;
         end else begin
            var_d = 1'b0;
            // a latency of 0 behaves like an ALU op (not pending)
            cnt_d = (latency == '0) ? '0 : latency - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         var_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         var_q <= var_d;
      end
   end

   assign pend     = (cnt_q != '0) | var_q;
   assign var_busy = var_q;
   assign pend_nxt = (cnt_d != '0) | var_d;

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard raising stall on RAW/WAW hits in ID.
// Optional stall performance counters are enabled by HAZARD_SB_PERF_CNT_EN.
module hazard_scoreboard #(
   parameter int NUM_REGS = hazard_pkg::NUM_ARCH_REGS,
   parameter int ADDR_W   = hazard_pkg::REG_ADDR_W,
   parameter int LAT_W    = hazard_pkg::LAT_W,
   parameter int CNT_W    = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs1_addr,
   input  logic              id_rs1_used,
   input  logic [ADDR_W-1:0] id_rs2_addr,
   input  logic              id_rs2_used,
   input  logic [ADDR_W-1:0] id_rd_addr,
   input  logic              id_rd_we,
   input  logic [LAT_W-1:0]  id_latency,
   input  logic              id_var_lat,
   input  logic              flush,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_rd_addr,
   output logic              stall,
   output logic [CNT_W-1:0]  busy_count
`ifdef HAZARD_SB_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       raw_stalls
`endif
);
   import hazard_pkg::*;

   localparam int          SPAN     = 1 << ADDR_W;
   localparam int unsigned BUSY_MAX = (32'd1 << CNT_W) - 32'd1;

   logic [SPAN-1:0]  eff_vec;
   logic [SPAN-1:0]  pend_nxt_vec;
   logic             issue;
   logic             raw1, raw2, waw;
   logic [CNT_W-1:0] busy_count_q, busy_count_d;
   int unsigned      pop;

   assign eff_vec[0]      = 1'b0;
   assign pend_nxt_vec[0] = 1'b0;

   for (genvar r = 1; r < SPAN; r++) begin : g_reg
      if (r < NUM_REGS) begin : g_ent
         logic issue_hit_r, wb_hit_r, pend_r, var_r;
         assign issue_hit_r = issue & (id_rd_addr == ADDR_W'(r));
         assign wb_hit_r    = wb_valid & (wb_rd_addr == ADDR_W'(r));

         hazard_sb_entry #(.CNT_BITS(LAT_W)) u_entry (
            .clk       (clk),
            .rst       (rst),
            .issue_hit (issue_hit_r),
            .latency   (id_latency),
            .var_lat   (id_var_lat),
            .wb_hit    (wb_hit_r),
            .pend      (pend_r),
            .var_busy  (var_r),
            .pend_nxt  (pend_nxt_vec[r])
         );

         // same-cycle completion of a variable-latency op is bypassed
         assign eff_vec[r] = pend_r & ~(wb_hit_r & var_r);
      end else begin : g_pad
         assign eff_vec[r]      = 1'b0;
         assign pend_nxt_vec[r] = 1'b0;
      end
   end

   assign raw1  = id_rs1_used & (id_rs1_addr != '0) & eff_vec[id_rs1_addr];
   assign raw2  = id_rs2_used & (id_rs2_addr != '0) & eff_vec[id_rs2_addr];
   assign waw   = id_rd_we    & (id_rd_addr  != '0) & eff_vec[id_rd_addr];
   assign stall = id_valid & ~flush & (raw1 | raw2 | waw);
   assign issue = id_valid & ~flush & ~stall & id_rd_we & (id_rd_addr != '0);

   always_comb begin
      pop = 0;
      for (int i = 0; i < SPAN; i++) pop = pop + 32'(pend_nxt_vec[i]);
      busy_count_d = (pop > BUSY_MAX) ? CNT_W'(BUSY_MAX) : CNT_W'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_count_q <= '0;
      else     busy_count_q <= busy_count_d;
   end

   assign busy_count = busy_count_q;

`ifdef HAZARD_SB_PERF_CNT_EN
   logic [31:0] stall_cycles_q, raw_stalls_q;
   logic        raw_stall;

   assign raw_stall = id_valid & ~flush & (raw1 | raw2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_q <= '0;
         raw_stalls_q   <= '0;
      end else begin
         if (stall)     stall_cycles_q <= stall_cycles_q + 32'd1;
         if (raw_stall) raw_stalls_q   <= raw_stalls_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign raw_stalls   = raw_stalls_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, hand
// sequences for variable latency and async reset, and randomized model check.
module tb_hazard_scoreboard;
   import hazard_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_var_lat;
   logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr, wb_rd_addr;
   logic [2:0] id_latency;
   logic       flush, wb_valid;
   logic       stall;
   logic [5:0] busy_count;
`ifdef HAZARD_SB_PERF_CNT_EN
   logic [31:0] stall_cycles, raw_stalls;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   int mcnt [32];
   bit mvar [32];
   int m_sc, m_rs;

   hazard_scoreboard dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_rs1_addr (id_rs1_addr),
      .id_rs1_used (id_rs1_used),
      .id_rs2_addr (id_rs2_addr),
      .id_rs2_used (id_rs2_used),
      .id_rd_addr  (id_rd_addr),
      .id_rd_we    (id_rd_we),
      .id_latency  (id_latency),
      .id_var_lat  (id_var_lat),
      .flush       (flush),
      .wb_valid    (wb_valid),
      .wb_rd_addr  (wb_rd_addr),
      .stall       (stall),
      .busy_count  (busy_count)
`ifdef HAZARD_SB_PERF_CNT_EN
      ,
      .stall_cycles(stall_cycles),
      .raw_stalls  (raw_stalls)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       valid;
      bit [4:0] rs1;
      bit       r1u;
      bit [4:0] rs2;
      bit       r2u;
      bit [4:0] rd;
      bit       we;
      bit [2:0] lat;
      bit       vl;
      bit       fl;
      bit       wbv;
      bit [4:0] wbr;
      bit       es;
      int       eb;
   } vec_t;

   function automatic vec_t v(bit valid, int rs1, bit r1u, int rs2, bit r2u, int rd, bit we,
                              int lat, bit vl, bit fl, bit wbv, int wbr, bit es, int eb);
      vec_t t;
      t.valid = valid; t.rs1 = 5'(rs1); t.r1u = r1u; t.rs2 = 5'(rs2); t.r2u = r2u;
      t.rd = 5'(rd); t.we = we; t.lat = 3'(lat); t.vl = vl; t.fl = fl;
      t.wbv = wbv; t.wbr = 5'(wbr); t.es = es; t.eb = eb;
      return t;
   endfunction

   task automatic apply(input vec_t t);
      id_valid = t.valid; id_rs1_addr = t.rs1; id_rs1_used = t.r1u;
      id_rs2_addr = t.rs2; id_rs2_used = t.r2u; id_rd_addr = t.rd; id_rd_we = t.we;
      id_latency = t.lat; id_var_lat = t.vl; flush = t.fl;
      wb_valid = t.wbv; wb_rd_addr = t.wbr;
   endtask

   task automatic check(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: register r is pending while its remaining count is
   // nonzero or an unfinished variable-latency write targets it
   function automatic bit m_eff(int r);
      if (r == 0) return 1'b0;
      if (mcnt[r] == 0 && !mvar[r]) return 1'b0;
      if (wb_valid && int'(wb_rd_addr) == r && mvar[r]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_raw();
      return id_valid && !flush &&
             ((id_rs1_used && m_eff(int'(id_rs1_addr))) || (id_rs2_used && m_eff(int'(id_rs2_addr))));
   endfunction

   function automatic bit m_stall();
      return m_raw() || (id_valid && !flush && id_rd_we && m_eff(int'(id_rd_addr)));
   endfunction

   function automatic int m_busy();
      int n = 0;
      for (int r = 1; r < 32; r++) if (mcnt[r] != 0 || mvar[r]) n++;
      return (n > 63) ? 63 : n;
   endfunction

   task automatic m_reset();
      for (int r = 0; r < 32; r++) begin mcnt[r] = 0; mvar[r] = 1'b0; end
      m_sc = 0; m_rs = 0;
   endtask

   task automatic m_step(input bit st, input bit raw);
      bit iss;
      int rd;
      iss = id_valid && !flush && !st && id_rd_we && id_rd_addr != 0;
      rd  = int'(id_rd_addr);
      if (st)  m_sc++;
      if (raw) m_rs++;
      for (int r = 1; r < 32; r++) begin
         if (mcnt[r] > 0) mcnt[r] = mcnt[r] - 1;
         if (wb_valid && int'(wb_rd_addr) == r) mvar[r] = 1'b0;
      end
      if (iss) begin
         if (id_var_lat) begin
            mvar[rd] = 1'b1; mcnt[rd] = 0;
         end else begin
            mvar[rd] = 1'b0;
            mcnt[rd] = (id_latency == 0) ? 0 : int'(id_latency) - 1;
         end
      end
   endtask

   task automatic run_cycle(input string nm, input bit use_model, input bit es, input int eb);
      bit st, raw;
      int exp_b;
      @(negedge clk);
      st  = m_stall();
      raw = m_raw();
      check({nm, " stall"}, longint'(stall), longint'(use_model ? st : es));
      @(posedge clk);
      m_step(st, raw);
      #1;
      exp_b = use_model ? m_busy() : eb;
      check({nm, " busy_count"}, longint'(busy_count), longint'(exp_b));
   endtask

   vec_t tbl[$];
   vec_t idle;

   initial begin
      idle = v(0, 0,0, 0,0, 0,0, 1,0,0, 0,0, 0,0);
      // load-use, ALU chain, x0
      tbl.push_back(v(1, 0,0, 0,0, 5,1, 2,0,0, 0,0, 0,1));
      tbl.push_back(v(1, 5,1, 0,0, 0,0, 1,0,0, 0,0, 1,0));
      tbl.push_back(v(1, 5,1, 0,0, 0,0, 1,0,0, 0,0, 0,0));
      tbl.push_back(v(1, 0,0, 0,0, 7,1, 1,0,0, 0,0, 0,0));
      tbl.push_back(v(1, 0,0, 7,1, 0,0, 1,0,0, 0,0, 0,0));
      tbl.push_back(v(1, 0,0, 0,0, 0,1, 4,0,0, 0,0, 0,0));
      tbl.push_back(v(1, 0,1, 0,0, 0,0, 1,0,0, 0,0, 0,0));
      // WAW: three stall cycles, then issue
      tbl.push_back(v(1, 0,0, 0,0, 3,1, 4,0,0, 0,0, 0,1));
      tbl.push_back(v(1, 0,0, 0,0, 3,1, 1,0,0, 0,0, 1,1));
      tbl.push_back(v(1, 0,0, 0,0, 3,1, 1,0,0, 0,0, 1,1));
      tbl.push_back(v(1, 0,0, 0,0, 3,1, 1,0,0, 0,0, 1,0));
      tbl.push_back(v(1, 0,0, 0,0, 3,1, 1,0,0, 0,0, 0,0));
      // WAW squashed by flush; entry still drains; invalid ID never stalls
      tbl.push_back(v(1, 0,0, 0,0, 3,1, 4,0,0, 0,0, 0,1));
      tbl.push_back(v(1, 0,0, 0,0, 3,1, 1,0,1, 0,0, 0,1));
      tbl.push_back(v(1, 0,0, 0,0, 3,1, 1,0,1, 0,0, 0,1));
      tbl.push_back(v(0, 3,1, 0,0, 3,1, 1,0,0, 0,0, 0,0));
      // latency 0 acts as ALU
      tbl.push_back(v(1, 0,0, 0,0, 8,1, 0,0,0, 0,0, 0,0));
      tbl.push_back(v(1, 8,1, 0,0, 0,0, 1,0,0, 0,0, 0,0));
      // unused sources don't stall
      tbl.push_back(v(1, 0,0, 0,0, 10,1, 3,0,0, 0,0, 0,1));
      tbl.push_back(v(1, 10,0, 10,0, 0,0, 1,0,0, 0,0, 0,1));
      tbl.push_back(v(1, 10,1, 0,0, 0,0, 1,0,0, 0,0, 1,0));
      // mul dependency: two stall cycles
      tbl.push_back(v(1, 0,0, 0,0, 11,1, int'(LAT_MUL),0,0, 0,0, 0,1));
      tbl.push_back(v(1, 11,1, 0,0, 0,0, 1,0,0, 0,0, 1,1));
      tbl.push_back(v(1, 0,0, 11,1, 0,0, 1,0,0, 0,0, 1,0));
      tbl.push_back(v(1, 0,0, 11,1, 0,0, 1,0,0, 0,0, 0,0));

      m_reset();
      apply(v(1, 5,1, 5,1, 5,1, 2,0,0, 0,0, 0,0));
      #3;
      check("reset stall", longint'(stall), 0);
      check("reset busy_count", longint'(busy_count), 0);
      @(negedge clk);
      rst = 1'b0;
      apply(idle);
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         apply(tbl[i]);
         run_cycle($sformatf("vec%0d", i), 1'b0, tbl[i].es, tbl[i].eb);
      end

      // variable-latency producer completes in the tenth dependent cycle
      apply(v(1, 0,0, 0,0, 9,1, 5,1,0, 0,0, 0,0));
      run_cycle("var issue", 1'b0, 1'b0, 1);
      for (int i = 1; i <= 9; i++) begin
         apply(v(1, 9,1, 0,0, 0,0, 1,0,0, 0,0, 0,0));
         run_cycle($sformatf("var wait%0d", i), 1'b0, 1'b1, 1);
      end
      apply(v(1, 9,1, 0,0, 0,0, 1,0,0, 1,9, 0,0));
      run_cycle("var wb bypass", 1'b0, 1'b0, 0);
      apply(v(1, 9,1, 0,0, 9,1, 1,0,0, 1,9, 0,0));
      run_cycle("var after wb", 1'b0, 1'b0, 0);

      // asynchronous reset in the middle of a stall
      apply(v(1, 0,0, 0,0, 4,1, 1,1,0, 0,0, 0,0));
      run_cycle("rst pre4", 1'b0, 1'b0, 1);
      apply(v(1, 0,0, 0,0, 6,1, 4,0,0, 0,0, 0,0));
      run_cycle("rst pre6", 1'b0, 1'b0, 2);
      apply(v(1, 4,1, 6,1, 0,0, 1,0,0, 0,0, 0,0));
      @(negedge clk);
      check("rst pre stall", longint'(stall), 1);
      #2 rst = 1'b1;
      #1;
      check("rst async stall", longint'(stall), 0);
      check("rst async busy_count", longint'(busy_count), 0);
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      run_cycle("rst post", 1'b0, 1'b0, 0);

      // randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         id_valid    = ($urandom_range(0, 7) != 0);
         id_rs1_addr = 5'($urandom_range(0, 7));
         id_rs1_used = 1'($urandom_range(0, 1));
         id_rs2_addr = 5'($urandom_range(0, 7));
         id_rs2_used = 1'($urandom_range(0, 1));
         id_rd_addr  = 5'($urandom_range(0, 7));
         id_rd_we    = 1'($urandom_range(0, 1));
         id_latency  = 3'($urandom_range(0, 7));
         id_var_lat  = ($urandom_range(0, 4) == 0);
         flush       = ($urandom_range(0, 7) == 0);
         wb_valid    = ($urandom_range(0, 2) == 0);
         wb_rd_addr  = 5'($urandom_range(0, 7));
         run_cycle($sformatf("rnd%0d", i), 1'b1, 1'b0, 0);
      end

`ifdef HAZARD_SB_PERF_CNT_EN
      check("stall_cycles", longint'(stall_cycles), longint'(m_sc));
      check("raw_stalls", longint'(raw_stalls), longint'(m_rs));
      // three RAW stall cycles followed by two WAW-only stall cycles
      apply(idle);
      @(negedge clk);
      rst = 1'b1;
      #2 rst = 1'b0;
      m_reset();
      apply(v(1, 0,0, 0,0, 12,1, 6,0,0, 0,0, 0,1));
      run_cycle("perf issue", 1'b0, 1'b0, 1);
      for (int i = 0; i < 3; i++) begin
         apply(v(1, 12,1, 0,0, 0,0, 1,0,0, 0,0, 0,0));
         run_cycle($sformatf("perf raw%0d", i), 1'b0, 1'b1, 1);
      end
      for (int i = 0; i < 2; i++) begin
         apply(v(1, 0,0, 0,0, 12,1, 1,0,0, 0,0, 0,0));
         run_cycle($sformatf("perf waw%0d", i), 1'b0, 1'b1, (i == 1) ? 0 : 1);
      end
      check("perf stall_cycles", longint'(stall_cycles), 5);
      check("perf raw_stalls", longint'(raw_stalls), 3);
`endif

      apply(idle);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
